// File: rtl/mst_fifo_pkg.sv
// Shared types and helpers for the FT60x master-FIFO loopback engine.
package mst_fifo_pkg;

    // Bus state machine: arbitration, read turn-on, read, write, bus turnaround.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_OE = 3'd1,
        ST_RD    = 3'd2,
        ST_WR    = 3'd3,
        ST_TURN  = 3'd4
    } state_e;

    // Direction of the most recent burst, used for round-robin arbitration.
    localparam logic DIR_RD = 1'b0;
    localparam logic DIR_WR = 1'b1;

    // Byte-enable width for a given data width.
    function automatic int calc_bw(input int dw);
        return dw / 8;
    endfunction

    // Number of buffer entries for a given address width.
    function automatic int calc_depth(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/mst_lpbk_buf.sv
// Circular buffer holding {be, data} words between capture and write-back.
// The read port looks ahead: while pop is high it already shows the entry
// that becomes the head after this edge, so the write side can reload its
// output register on the same edge that retires the current word.
module mst_lpbk_buf
    import mst_fifo_pkg::*;
#(
    parameter int WW = 18,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [WW-1:0] din,
    output logic [WW-1:0] dout,
    output logic [AW:0]   level
);

    localparam int            DEPTH    = calc_depth(AW);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);
    localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   LVL_ZERO = (AW + 1)'(0);

    logic [WW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;

    // Pointer and occupancy update; flush wins, push and pop never coincide.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = PTR_ZERO;
            rd_ptr_d = PTR_ZERO;
            level_d  = LVL_ZERO;
        end else if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            level_d  = level_q + LVL_ONE;
        end else if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            level_d  = level_q - LVL_ONE;
        end else begin
            level_d  = level_q;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            level_q  <= LVL_ZERO;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = pop ? mem_q[rd_ptr_q + PTR_ONE] : mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/mst_fifo_lpbk.sv
// FT60x 245-mode master FIFO loopback: reads words while the chip has data,
// buffers them, and writes them back when the chip can accept them, with
// round-robin direction arbitration and a per-burst word limit.
module mst_fifo_lpbk
    import mst_fifo_pkg::*;
#(
    parameter int  DW    = 16,
    parameter int  AW    = 10,
    parameter int  BURST = 256,
    localparam int BW    = calc_bw(DW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          rxf_n,
    input  logic          txe_n,
    input  logic [DW-1:0] idata,
    input  logic [BW-1:0] ibe,
    output logic [DW-1:0] odata,
    output logic [BW-1:0] obe,
    output logic          dt_oe_n,
    output logic          be_oe_n,
    output logic          oe_n,
    output logic          rd_n,
    output logic          wr_n,
    output logic [AW:0]   level,
    output logic [31:0]   rx_words,
    output logic [31:0]   tx_words,
    output logic          busy
);

    localparam int            DEPTH      = calc_depth(AW);
    localparam int            CW         = $clog2(BURST + 1);
    localparam logic [AW:0]   LVL_FULL   = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   LVL_ALMOST = (AW + 1)'(DEPTH - 1);
    localparam logic [AW:0]   LVL_ONE    = (AW + 1)'(1);
    localparam logic [AW:0]   LVL_ZERO   = (AW + 1)'(0);
    localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(BURST);
    localparam logic [31:0]   WORD_ONE   = 32'd1;

    state_e         state_q, state_d;
    logic           last_dir_q, last_dir_d;
    logic [CW-1:0]  burst_q, burst_d;
    logic           oe_n_q, oe_n_d;
    logic           rd_n_q, rd_n_d;
    logic           wr_n_q, wr_n_d;
    logic           dt_oe_n_q, dt_oe_n_d;
    logic [DW-1:0]  odata_q, odata_d;
    logic [BW-1:0]  obe_q, obe_d;
    logic [31:0]    rx_q, rx_d;
    logic [31:0]    tx_q, tx_d;
    logic           flush_pend_q, flush_pend_d;
    logic           busy_q, busy_d;

    logic           rd_ok_s, wr_ok_s;
    logic           push_s, pop_s, flush_s;
    logic [AW:0]    lvl_s;
    logic [DW+BW-1:0] head_s;
    logic [CW-1:0]  burst_inc_s;

    mst_lpbk_buf #(
        .WW (DW + BW),
        .AW (AW)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .flush (flush_s),
        .din   ({ibe, idata}),
        .dout  (head_s),
        .level (lvl_s)
    );

    // Buffer controls are pure functions of state and pad inputs, kept out of
    // the FSM block so the look-ahead read path does not loop through it.
    assign rd_ok_s     = !rxf_n && (lvl_s < LVL_FULL);
    assign wr_ok_s     = !txe_n && (lvl_s > LVL_ZERO);
    assign push_s      = (state_q == ST_RD) && !rd_n_q && !rxf_n;
    assign pop_s       = (state_q == ST_WR) && !wr_n_q && !txe_n;
    assign flush_s     = (state_q == ST_IDLE) && (flush || flush_pend_q);
    assign burst_inc_s = burst_q + CNT_ONE;

    // Next state, next strobes and counter updates; strobes default to idle-high.
    always_comb begin
        state_d      = state_q;
        last_dir_d   = last_dir_q;
        burst_d      = burst_q;
        oe_n_d       = 1'b1;
        rd_n_d       = 1'b1;
        wr_n_d       = 1'b1;
        dt_oe_n_d    = 1'b1;
        odata_d      = odata_q;
        obe_d        = obe_q;
        rx_d         = rx_q;
        tx_d         = tx_q;
        flush_pend_d = flush_pend_q | flush;

        case (state_q)
            ST_IDLE: begin
                if (flush || flush_pend_q) begin
                    // Flush takes the whole cycle; no burst starts alongside it.
                    flush_pend_d = 1'b0;
                end else if (rd_ok_s && (!wr_ok_s || (last_dir_q == DIR_WR))) begin
                    state_d    = ST_RD_OE;
                    oe_n_d     = 1'b0;
                    burst_d    = CNT_ZERO;
                    last_dir_d = DIR_RD;
                end else if (wr_ok_s) begin
                    state_d    = ST_WR;
                    wr_n_d     = 1'b0;
                    dt_oe_n_d  = 1'b0;
                    odata_d    = head_s[DW-1:0];
                    obe_d      = head_s[DW +: BW];
                    burst_d    = CNT_ZERO;
                    last_dir_d = DIR_WR;
                end else begin
                    state_d    = ST_IDLE;
                end
            end

            ST_RD_OE: begin
                state_d = ST_RD;
                oe_n_d  = 1'b0;
                rd_n_d  = 1'b0;
            end

            ST_RD: begin
                if (push_s) begin
                    rx_d    = rx_q + WORD_ONE;
                    burst_d = burst_inc_s;
                end else begin
                    rx_d    = rx_q;
                end
                // Stop on empty chip, on a capture that fills the buffer, or at the burst limit.
                if (rxf_n || (lvl_s == LVL_ALMOST) || (burst_inc_s == CNT_MAX)) begin
                    state_d = ST_TURN;
                end else begin
                    oe_n_d  = 1'b0;
                    rd_n_d  = 1'b0;
                end
            end

            ST_WR: begin
                if (pop_s) begin
                    tx_d    = tx_q + WORD_ONE;
                    burst_d = burst_inc_s;
                    if ((lvl_s == LVL_ONE) || (burst_inc_s == CNT_MAX)) begin
                        state_d = ST_TURN;
                    end else begin
                        wr_n_d    = 1'b0;
                        dt_oe_n_d = 1'b0;
                        odata_d   = head_s[DW-1:0];
                        obe_d     = head_s[DW +: BW];
                    end
                end else begin
                    // Back-pressure: keep the current head for the next write burst.
                    state_d = ST_TURN;
                end
            end

            ST_TURN: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // FSM, strobe, output-data and counter registers; reset drives the bus idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_dir_q   <= DIR_WR;
            burst_q      <= CNT_ZERO;
            oe_n_q       <= 1'b1;
            rd_n_q       <= 1'b1;
            wr_n_q       <= 1'b1;
            dt_oe_n_q    <= 1'b1;
            odata_q      <= {DW{1'b0}};
            obe_q        <= {BW{1'b0}};
            rx_q         <= 32'd0;
            tx_q         <= 32'd0;
            flush_pend_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_dir_q   <= last_dir_d;
            burst_q      <= burst_d;
            oe_n_q       <= oe_n_d;
            rd_n_q       <= rd_n_d;
            wr_n_q       <= wr_n_d;
            dt_oe_n_q    <= dt_oe_n_d;
            odata_q      <= odata_d;
            obe_q        <= obe_d;
            rx_q         <= rx_d;
            tx_q         <= tx_d;
            flush_pend_q <= flush_pend_d;
            busy_q       <= busy_d;
        end
    end

    assign odata    = odata_q;
    assign obe      = obe_q;
    assign dt_oe_n  = dt_oe_n_q;
    assign be_oe_n  = dt_oe_n_q;
    assign oe_n     = oe_n_q;
    assign rd_n     = rd_n_q;
    assign wr_n     = wr_n_q;
    assign level    = lvl_s;
    assign rx_words = rx_q;
    assign tx_words = tx_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_mst_fifo_lpbk.sv
// Scoreboard bench for mst_fifo_lpbk in a single small configuration
// (32-bit bus, 4-entry buffer, 2-word bursts) so that width, full-buffer and
// burst-limit behaviour are all reachable with short directed sequences.
module tb_mst_fifo_lpbk;

    localparam int DW    = 32;
    localparam int BW    = 4;
    localparam int AW    = 2;
    localparam int BURST = 2;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          rxf_n;
    logic          txe_n;
    logic [DW-1:0] idata;
    logic [BW-1:0] ibe;
    logic [DW-1:0] odata;
    logic [BW-1:0] obe;
    logic          dt_oe_n, be_oe_n, oe_n, rd_n, wr_n;
    logic [AW:0]   level;
    logic [31:0]   rx_words, tx_words;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int viol_rd = 0;
    int viol_wr = 0;
    int rd_run = 0;
    int wr_run = 0;
    logic oe_prev = 1'b1;
    logic wr_prev = 1'b1;

    logic [DW-1:0] rsrc_d[$];
    logic [BW-1:0] rsrc_b[$];
    logic [DW-1:0] exp_d[$];
    logic [BW-1:0] exp_b[$];
    logic          dir_log[$];
    logic          dir_exp[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    mst_fifo_lpbk #(.DW(DW), .AW(AW), .BURST(BURST)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .rxf_n    (rxf_n),
        .txe_n    (txe_n),
        .idata    (idata),
        .ibe      (ibe),
        .odata    (odata),
        .obe      (obe),
        .dt_oe_n  (dt_oe_n),
        .be_oe_n  (be_oe_n),
        .oe_n     (oe_n),
        .rd_n     (rd_n),
        .wr_n     (wr_n),
        .level    (level),
        .rx_words (rx_words),
        .tx_words (tx_words),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_rx();
        if (rsrc_d.size() > 0) begin
            rxf_n = 1'b0;
            idata = rsrc_d[0];
            ibe   = rsrc_b[0];
        end else begin
            rxf_n = 1'b1;
            idata = '0;
            ibe   = '0;
        end
    endtask

    // Offer a word on the read side; if it should come back, log it as expected.
    task automatic offer(input logic [DW-1:0] d, input logic [BW-1:0] b, input bit expect_back);
        rsrc_d.push_back(d);
        rsrc_b.push_back(b);
        if (expect_back) begin
            exp_d.push_back(d);
            exp_b.push_back(b);
        end
    endtask

    // FT60x read-side model: consumes a word on each capturing edge.
    always begin
        @(posedge clk);
        if (!rd_n && !rxf_n && rsrc_d.size() > 0) begin
            void'(rsrc_d.pop_front());
            void'(rsrc_b.pop_front());
            rd_run++;
            if (rd_run > BURST) viol_rd++;
        end
        if (rd_n) rd_run = 0;
        #1;
        drive_rx();
        @(negedge clk);
        drive_rx();
    end

    // Write-side monitor: compares each accepted word with the scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!wr_n && !txe_n) begin
                if (exp_d.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wb_unexpected: got %0h expected no write", odata);
                end else begin
                    chk("wb_data", odata, exp_d[0]);
                    chk("wb_be", 32'(obe), 32'(exp_b[0]));
                    void'(exp_d.pop_front());
                    void'(exp_b.pop_front());
                end
                wr_run++;
                if (wr_run > BURST) viol_wr++;
            end
            if (wr_n) wr_run = 0;
            if (!wr_n && level == 3'd0) viol_wr++;
            if (!rd_n && level == 3'd4) viol_wr++;
            if (dt_oe_n != be_oe_n || dt_oe_n != wr_n) viol_wr++;
            if (!oe_n && oe_prev) dir_log.push_back(1'b0);
            if (!wr_n && wr_prev) dir_log.push_back(1'b1);
        end
        oe_prev = oe_n;
        wr_prev = wr_n;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1;
        flush = 1'b0;
        txe_n = 1'b1;
        #2 rst_n = 1'b0;
        tick(3);

        // Reset state
        chk("rst_oe_n", 32'(oe_n), 32'd1);
        chk("rst_rd_n", 32'(rd_n), 32'd1);
        chk("rst_wr_n", 32'(wr_n), 32'd1);
        chk("rst_dt_oe_n", 32'(dt_oe_n), 32'd1);
        chk("rst_be_oe_n", 32'(be_oe_n), 32'd1);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_odata", odata, 32'd0);
        chk("rst_obe", 32'(obe), 32'd0);
        chk("rst_rx", rx_words, 32'd0);
        chk("rst_tx", tx_words, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Read then write: four words, full byte enables
        for (int i = 1; i <= 4; i++) offer(32'(i), 4'hF, 1'b1);
        tick(1);
        chk("rd_start_oe_n", 32'(oe_n), 32'd0);
        chk("rd_start_rd_n", 32'(rd_n), 32'd1);
        tick(1);
        chk("rd_strobe_rd_n", 32'(rd_n), 32'd0);
        for (int i = 0; i < 40; i++) begin
            if (level == 3'd4 && !busy) break;
            tick(1);
        end
        chk("t1_level", 32'(level), 32'd4);
        chk("t1_rx", rx_words, 32'd4);
        txe_n = 1'b0;
        tick(1);
        chk("wr_start_wr_n", 32'(wr_n), 32'd0);
        chk("wr_start_odata", odata, 32'd1);
        for (int i = 0; i < 40; i++) begin
            if (tx_words == 32'd4 && !busy) break;
            tick(1);
        end
        chk("t1_tx", tx_words, 32'd4);
        chk("t1_level_after", 32'(level), 32'd0);
        chk("t1_sb_empty", 32'(exp_d.size()), 32'd0);
        txe_n = 1'b1;

        // Buffer full: ten words offered, only four fit
        for (int i = 0; i < 10; i++) offer(32'hA5A5_0010 + 32'(i), 4'h3, (i < 4));
        for (int i = 0; i < 60; i++) begin
            if (level == 3'd4 && !busy) break;
            tick(1);
        end
        tick(5);
        chk("full_level", 32'(level), 32'd4);
        chk("full_rx", rx_words, 32'd8);
        chk("full_left", 32'(rsrc_d.size()), 32'd6);
        chk("full_rd_n", 32'(rd_n), 32'd1);
        rsrc_d.delete();
        rsrc_b.delete();
        txe_n = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (tx_words == 32'd8 && !busy) break;
            tick(1);
        end
        chk("full_tx", tx_words, 32'd8);
        chk("full_sb_empty", 32'(exp_d.size()), 32'd0);
        txe_n = 1'b1;

        // Write back-pressure on the third word
        for (int i = 0; i < 4; i++) offer(32'h1234_5600 + 32'(i), 4'hF, 1'b1);
        for (int i = 0; i < 40; i++) begin
            if (level == 3'd4 && !busy) break;
            tick(1);
        end
        txe_n = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!wr_n && odata == 32'h1234_5602) break;
            tick(1);
        end
        txe_n = 1'b1;
        tick(1);
        chk("bp_wr_n", 32'(wr_n), 32'd1);
        chk("bp_dt_oe_n", 32'(dt_oe_n), 32'd1);
        chk("bp_tx", tx_words, 32'd10);
        chk("bp_level", 32'(level), 32'd2);
        tick(2);
        txe_n = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (tx_words == 32'd12 && !busy) break;
            tick(1);
        end
        chk("bp_tx_done", tx_words, 32'd12);
        chk("bp_sb_empty", 32'(exp_d.size()), 32'd0);
        txe_n = 1'b1;

        // Arbitration and burst limit: both sides ready, last burst was a read
        for (int i = 0; i < 3; i++) offer(32'hC0DE_0000 + 32'(i), 4'h5, 1'b1);
        for (int i = 0; i < 40; i++) begin
            if (level == 3'd3 && !busy) break;
            tick(1);
        end
        dir_log.delete();
        for (int i = 0; i < 4; i++) offer(32'hBEEF_0000 + 32'(i), 4'hA, 1'b1);
        txe_n = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (tx_words == 32'd19 && level == 3'd0 && !busy) break;
            tick(1);
        end
        chk("arb_tx", tx_words, 32'd19);
        chk("arb_rx", rx_words, 32'd19);
        chk("arb_bursts", 32'(dir_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < dir_log.size(); i++) begin
            chk($sformatf("arb_dir%0d", i), 32'(dir_log[i]), 32'(dir_exp[i]));
        end
        chk("arb_sb_empty", 32'(exp_d.size()), 32'd0);
        txe_n = 1'b1;

        // Flush pulsed during a read burst is deferred until IDLE
        offer(32'hF1F1_0000, 4'hF, 1'b0);
        offer(32'hF1F1_0001, 4'hF, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (!rd_n) break;
            tick(1);
        end
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        chk("flush_deferred_level", 32'(level), 32'd1);
        chk("flush_deferred_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            tick(1);
        end
        tick(1);
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_rx", rx_words, 32'd21);

        // Flush held in IDLE blocks a read start
        flush = 1'b1;
        offer(32'hF1F1_0002, 4'hF, 1'b0);
        tick(3);
        chk("flush_idle_oe_n", 32'(oe_n), 32'd1);
        chk("flush_idle_level", 32'(level), 32'd0);
        flush = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (level == 3'd1 && !busy) break;
            tick(1);
        end
        chk("post_flush_rx", rx_words, 32'd22);

        // Reset asserted mid-write forces the bus idle at once
        offer(32'hDEAD_0000, 4'hF, 1'b0);
        offer(32'hDEAD_0001, 4'hF, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (level == 3'd3 && !busy) break;
            tick(1);
        end
        txe_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!wr_n) break;
            tick(1);
        end
        chk("mid_wr_wr_n_low", 32'(wr_n), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_wr_n", 32'(wr_n), 32'd1);
        chk("arst_dt_oe_n", 32'(dt_oe_n), 32'd1);
        chk("arst_be_oe_n", 32'(be_oe_n), 32'd1);
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_rx", rx_words, 32'd0);
        txe_n = 1'b1;
        rsrc_d.delete();
        rsrc_b.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(3);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_tx", tx_words, 32'd0);

        // Invariants gathered by the models over the whole run
        chk("rd_burst_limit", 32'(viol_rd), 32'd0);
        chk("wr_invariants", 32'(viol_wr), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mst_fifo_lpbk.md
# mst_fifo_lpbk

Parametrised loopback engine for the FT60x 245-mode master FIFO bus, the successor to the fixed-width loopback test path. It reads words from the FT60x whenever the chip has data, stores data and byte enables in an internal circular buffer, and writes them back when the chip can accept them. It adds configurable bus width, buffer depth and burst length, round-robin read/write arbitration, flush and traffic counters. It sits between `mst_fifo_io`-style pad logic (split `tc_`/`tp_` signals) and the rest of the design.

## Interface
- `DW`, 16: data bus width; legal values are 16 and 32. Byte-enable width `BW = DW/8`.
- `AW`, 10: buffer address width; `DEPTH = 2**AW` entries of `DW+BW` bits.
- `BURST`, 256: maximum number of words per read or write burst before arbitration is re-run; must be at least 1.
- `clk` in 1: bus clock from the FT60x. One clock domain only.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: level-sensitive request to empty the buffer.
- `rxf_n` in 1: low = FT60x has read data.
- `txe_n` in 1: low = FT60x can accept write data.
- `idata` in DW, `ibe` in BW: read data and byte enables from the pads.
- `odata` out DW, `obe` out BW: registered write data and byte enables.
- `dt_oe_n` out 1, `be_oe_n` out 1: FPGA drive enables for data and BE; both are always equal.
- `oe_n`, `rd_n`, `wr_n` out 1: FT60x bus strobes, all registered.
- `level` out AW+1: current buffer occupancy, 0..DEPTH.
- `rx_words` out 32, `tx_words` out 32: words captured / words accepted since reset. Both wrap modulo 2^32.
- `busy` out 1: high when the state machine is not in IDLE.

## Operation
- **States:** IDLE, RD_OE, RD, WR, TURN.
- **Reset values:** state = IDLE, last_dir = WR, all strobes and output enables = 1, `odata` = `obe` = 0, `level` = 0, pointers = 0, counters = 0.
- **IDLE arbitration:**
  - `rd_ok` = !rxf_n && level < DEPTH.
  - `wr_ok` = !txe_n && level > 0.
  - If only one is true, start that burst. If both are true, start the direction opposite to last_dir.
  - Starting a read goes to RD_OE and sets oe_n=0. Starting a write goes to WR and sets wr_n=0, dt_oe_n=0, and loads `odata`/`obe` with the head entry.
  - The burst counter is cleared when a burst starts, and last_dir is updated.
- **RD_OE:** lasts one cycle, then goes to RD with rd_n=0 and oe_n kept at 0.
- **RD:**
  - A word is captured on each edge where rd_n=0 and rxf_n=0. Capture pushes {ibe, idata}, increments `level`, `rx_words` and the burst count.
  - RD exits to TURN (rd_n=1, oe_n=1) on the first edge where rxf_n=1, or where the post-capture level equals DEPTH, or where the burst count reaches BURST.
- **WR:**
  - A word is accepted on each edge where wr_n=0 and txe_n=0. Acceptance pops the buffer, increments `tx_words` and the burst count, and loads the next head into `odata`/`obe`.
  - WR exits to TURN (wr_n=1, dt_oe_n=1) when txe_n=1 is sampled (no pop), when the post-pop level is 0, or when the burst count reaches BURST.
- **TURN:** lasts one cycle with all strobes and enables high, then returns to IDLE.
- **Flush:**
  - Acts only in IDLE: pointers and `level` are cleared, and no burst starts in that cycle. Counters are not cleared.
  - A flush asserted in any other state is deferred until IDLE.
- **Buffer:** one write port and one asynchronous read port. A push and a pop never happen in the same cycle, because the bus is half-duplex. Pointers wrap modulo DEPTH.

## Timing
- Read start: rxf_n low is sampled in IDLE at edge 0. oe_n goes low in cycle 1, rd_n goes low in cycle 2, and the first capture is at the edge ending cycle 2.
- Write start: wr_ok is sampled at edge 0. wr_n, dt_oe_n and `odata` are valid in cycle 1, and the first possible accept is at the edge ending cycle 1.
- Sustained rate is one word per clock in RD or WR.
- Overhead between bursts: a read burst costs 3 idle cycles (RD_OE, TURN, IDLE); a write burst costs 2 (TURN, IDLE).
- No overflow is possible: rd_n is low only when level < DEPTH at the preceding edge.
- No underflow is possible: wr_n is low only when level > 0.
- Loopback latency: a word captured at edge k can be driven no earlier than 3 cycles later (TURN, IDLE, WR).
- Asserting rst_n low mid-burst forces all strobes high asynchronously. Buffered data is lost.

## Structure
- **Package `mst_fifo_pkg`:** state enum, direction constants (DIR_RD, DIR_WR), `BW`/`DEPTH` derivation functions.
- **Sub-module `mst_lpbk_buf`:** register array plus pointers and level. Ports: push, pop, flush, din, dout, level.
- The FSM, burst counter and traffic counters live in the top module.

## Test plan
- **Read then write:** rxf_n low for 4 words 0x0001..0x0004 with BE 2'b11, then txe_n low. Required: level rises to 4, then the same 4 words and BEs appear on `odata` in order; `rx_words` = `tx_words` = 4.
- **Buffer full:** AW=2, rxf_n held low with 10 words offered. Required: exactly 4 captured, rd_n rises the cycle after the 4th capture, and `level` = 4.
- **Write back-pressure:** txe_n goes high mid-burst on the 3rd word. Required: no pop, TURN, then the write resumes with the same 3rd word after txe_n returns low.
- **Arbitration and burst limit:** BURST=2, both sides ready, buffer holding 5 words. Required: bursts alternate RD/WR, and no burst exceeds 2 words.
- **Width and BE:** DW=32 with BE 4'b0011. Required: `obe` = 4'b0011 and `odata` bit-exact on write-back.
- **Flush and reset:** flush pulsed during RD is deferred until IDLE, after which level = 0 and `rx_words` is unchanged. rst_n low mid-WR sets wr_n=1 and dt_oe_n=1 immediately.
